// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, byte length and the
// ACK/NACK bus levels. The ACK/NACK constants are also used by the master
// controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE_DATA,
        ST_WRITE_ACK,
        ST_READ_DATA,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_state_t;

    localparam int unsigned BYTE_BITS = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_monitor.sv
// I2C line conditioning: SYNC_STAGES-deep synchronizers on SCL and SDA,
// followed by a one-flop edge register on each synchronized line.
//   clock, reset : system clock, asynchronous active-high reset
//   SCL, SDAIn   : raw bus pins (asynchronous)
//   SCLRise/Fall : one-cycle strobes on synchronized SCL edges
//   StartSeen    : synced SDA fell while synced SCL stayed high
//   StopSeen     : synced SDA rose while synced SCL stayed high
//   SDASync      : synchronized SDA level
module i2c_line_monitor #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic SCL,
    input  logic SDAIn,
    output logic SCLRise,
    output logic SCLFall,
    output logic StartSeen,
    output logic StopSeen,
    output logic SDASync
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDAIn};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus level is high, so reset to 1 to avoid spurious edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // START/STOP need SCL high in both the current and previous sample, so
    // an SCL edge coinciding with an SDA edge counts as a data bit.
    always_comb begin
        SCLRise   = scl_s & ~scl_prev_q;
        SCLFall   = ~scl_s & scl_prev_q;
        StartSeen = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        StopSeen  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        SDASync   = sda_s;
    end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target responder. Matches a 7-bit ADDRESS, ACKs it, receives write
// bytes (ACKing each) and shifts out local read bytes.
//   clock, reset   : system clock (>= 8x SCL), asynchronous active-high reset
//   SCL, SDAIn     : bus pins; SDADriveLow is the open-drain pull-down enable
//   TxData         : read byte, latched when TxRequest pulses
//   TxRequest      : one-cycle pulse as TxData is latched
//   RxData/RxValid : last written byte and its one-cycle update strobe
//   ReadNotWrite   : R/W bit of the current matched transfer
//   Busy           : high from address match until STOP / START
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDRESS     = 7'h3C,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SCL,
    input  logic       SDAIn,
    output logic       SDADriveLow,
    input  logic [7:0] TxData,
    output logic       TxRequest,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       ReadNotWrite,
    output logic       Busy
);

    localparam logic [3:0] CNT_FULL = 4'(BYTE_BITS);
    localparam logic [3:0] CNT_LAST = 4'(BYTE_BITS - 1);

    logic scl_rise, scl_fall, start_seen, stop_seen, sda_sync;

    i2c_line_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_monitor (
        .clock    (clock),
        .reset    (reset),
        .SCL      (SCL),
        .SDAIn    (SDAIn),
        .SCLRise  (scl_rise),
        .SCLFall  (scl_fall),
        .StartSeen(start_seen),
        .StopSeen (stop_seen),
        .SDASync  (sda_sync)
    );

    i2c_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_request_q, tx_request_d;
    logic       sda_drive_low_q, sda_drive_low_d;
    logic       read_not_write_q, read_not_write_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            tx_shift_q       <= '0;
            rx_data_q        <= '0;
            rx_valid_q       <= 1'b0;
            tx_request_q     <= 1'b0;
            sda_drive_low_q  <= 1'b0;
            read_not_write_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            tx_shift_q       <= tx_shift_d;
            rx_data_q        <= rx_data_d;
            rx_valid_q       <= rx_valid_d;
            tx_request_q     <= tx_request_d;
            sda_drive_low_q  <= sda_drive_low_d;
            read_not_write_q <= read_not_write_d;
            busy_q           <= busy_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        tx_shift_d       = tx_shift_q;
        rx_data_d        = rx_data_q;
        rx_valid_d       = 1'b0;
        tx_request_d     = 1'b0;
        sda_drive_low_d  = sda_drive_low_q;
        read_not_write_d = read_not_write_q;
        busy_d           = busy_q;

        if (stop_seen) begin
            state_d         = ST_IDLE;
            bit_cnt_d       = '0;
            sda_drive_low_d = 1'b0;
            busy_d          = 1'b0;
        end else if (start_seen) begin
            state_d         = ST_ADDR;
            bit_cnt_d       = '0;
            sda_drive_low_d = 1'b0;
            busy_d          = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q != CNT_FULL) begin
                        shift_d   = {shift_q[6:0], sda_sync};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == CNT_FULL) begin
                        bit_cnt_d = '0;
                        if (shift_q[7:1] == ADDRESS) begin
                            sda_drive_low_d  = 1'b1;
                            read_not_write_d = shift_q[0];
                            busy_d           = 1'b1;
                            state_d          = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (read_not_write_q) begin
                            tx_shift_d      = TxData;
                            tx_request_d    = 1'b1;
                            sda_drive_low_d = ~TxData[7];
                            state_d         = ST_READ_DATA;
                        end else begin
                            sda_drive_low_d = 1'b0;
                            state_d         = ST_WRITE_DATA;
                        end
                    end
                end

                ST_WRITE_DATA: begin
                    if (scl_rise && bit_cnt_q != CNT_FULL) begin
                        shift_d   = {shift_q[6:0], sda_sync};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == CNT_LAST) begin
                            rx_data_d  = {shift_q[6:0], sda_sync};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == CNT_FULL) begin
                        bit_cnt_d       = '0;
                        sda_drive_low_d = 1'b1;
                        state_d         = ST_WRITE_ACK;
                    end
                end

                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d       = '0;
                        sda_drive_low_d = 1'b0;
                        state_d         = ST_WRITE_DATA;
                    end
                end

                // Bit 7 is already on the bus at entry; the counter tracks
                // the falls that present bits 6..0 and then the release.
                ST_READ_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_LAST) begin
                            bit_cnt_d       = '0;
                            sda_drive_low_d = 1'b0;
                            state_d         = ST_READ_ACK;
                        end else begin
                            tx_shift_d      = {tx_shift_q[6:0], 1'b0};
                            sda_drive_low_d = ~tx_shift_q[6];
                            bit_cnt_d       = bit_cnt_q + 4'd1;
                        end
                    end
                end

                // bit_cnt = 1 records a master ACK seen on this SCL-rise.
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync == NACK) begin
                            bit_cnt_d = '0;
                            state_d   = ST_IGNORE;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d       = '0;
                        tx_shift_d      = TxData;
                        tx_request_d    = 1'b1;
                        sda_drive_low_d = ~TxData[7];
                        state_d         = ST_READ_DATA;
                    end
                end

                ST_IGNORE: sda_drive_low_d = 1'b0;

                default: begin
                    state_d         = ST_IDLE;
                    bit_cnt_d       = '0;
                    sda_drive_low_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        SDADriveLow  = sda_drive_low_q;
        TxRequest    = tx_request_q;
        RxData       = rx_data_q;
        RxValid      = rx_valid_q;
        ReadNotWrite = read_not_write_q;
        Busy         = busy_q;
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Self-checking bench for i2c_target_responder: a bit-banged I2C master on a
// wired-AND SDA line, with a transaction-level expectation of ACKs, received
// bytes and read bytes.
module tb_i2c_target_responder;

    localparam logic [6:0] TGT_ADDR = 7'h3C;
    localparam int Q = 80;  // quarter SCL period = 8 system clocks

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       SDADriveLow;
    logic [7:0] TxData;
    logic       TxRequest;
    logic [7:0] RxData;
    logic       RxValid;
    logic       ReadNotWrite;
    logic       Busy;
    logic       sda_bus;

    assign sda_bus = sda_m & ~SDADriveLow;

    i2c_target_responder #(
        .ADDRESS    (TGT_ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .SCL         (scl_m),
        .SDAIn       (sda_bus),
        .SDADriveLow (SDADriveLow),
        .TxData      (TxData),
        .TxRequest   (TxRequest),
        .RxData      (RxData),
        .RxValid     (RxValid),
        .ReadNotWrite(ReadNotWrite),
        .Busy        (Busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Local-logic side: TxData supplies the next queued byte after each TxRequest.
    logic [7:0] tx_bytes [0:15];
    int         tx_req_total = 0;
    int         tx_base      = 0;
    logic [7:0] rx_obs [$];
    logic       overlap      = 1'b0;

    assign TxData = tx_bytes[4'(tx_req_total - tx_base)];

    initial begin
        forever begin
            @(negedge clock);
            if (RxValid) rx_obs.push_back(RxData);
            if (TxRequest) tx_req_total++;
            if (RxValid && TxRequest) overlap = 1'b1;
        end
    end

    // ---------------- bus master primitives ----------------
    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        #Q scl_m = 1'b1;
        #Q s = sda_bus;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_rep_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(master_ack ? 1'b0 : 1'b1, s);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic       ack;
        logic [7:0] rb;
        logic [7:0] wbytes [0:2];
        int         rx_base;
        int         n;
        logic       match;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] exp_byte;

        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
        #52;
        check_eq("rst_sda",  32'(SDADriveLow), 32'd0);
        check_eq("rst_rxd",  32'(RxData), 32'h00);
        check_eq("rst_rxv",  32'(RxValid), 32'd0);
        check_eq("rst_txr",  32'(TxRequest), 32'd0);
        check_eq("rst_rnw",  32'(ReadNotWrite), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        reset = 1'b0;
        #100;

        // Write 0x3C: 0x5A, 0xA5
        rx_base = rx_obs.size();
        bus_start();
        write_byte({TGT_ADDR, 1'b0}, ack);
        check_eq("w_addr_ack", 32'(ack), 32'd1);
        check_eq("w_busy", 32'(Busy), 32'd1);
        check_eq("w_rnw", 32'(ReadNotWrite), 32'd0);
        write_byte(8'h5A, ack);
        check_eq("w_d0_ack", 32'(ack), 32'd1);
        write_byte(8'hA5, ack);
        check_eq("w_d1_ack", 32'(ack), 32'd1);
        bus_stop();
        check_eq("w_rx_cnt", 32'(rx_obs.size() - rx_base), 32'd2);
        if (rx_obs.size() - rx_base == 2) begin
            check_eq("w_rx0", 32'(rx_obs[rx_base]), 32'h5A);
            check_eq("w_rx1", 32'(rx_obs[rx_base+1]), 32'hA5);
        end
        check_eq("w_busy_stop", 32'(Busy), 32'd0);

        // Wrong address 0x3D
        rx_base = rx_obs.size();
        bus_start();
        write_byte({7'h3D, 1'b0}, ack);
        check_eq("na_addr_ack", 32'(ack), 32'd0);
        check_eq("na_busy", 32'(Busy), 32'd0);
        write_byte(8'($urandom), ack);
        check_eq("na_data_ack", 32'(ack), 32'd0);
        bus_stop();
        check_eq("na_rx_cnt", 32'(rx_obs.size() - rx_base), 32'd0);

        // Read 0x3C: 0xC3 (ACK), 0x81 (NACK)
        tx_base = tx_req_total;
        tx_bytes[0] = 8'hC3;
        tx_bytes[1] = 8'h81;
        bus_start();
        write_byte({TGT_ADDR, 1'b1}, ack);
        check_eq("r_addr_ack", 32'(ack), 32'd1);
        check_eq("r_rnw", 32'(ReadNotWrite), 32'd1);
        read_byte(1'b1, rb);
        check_eq("r_b0", 32'(rb), 32'hC3);
        read_byte(1'b0, rb);
        check_eq("r_b1", 32'(rb), 32'h81);
        #40;
        check_eq("r_sda_rel", 32'(SDADriveLow), 32'd0);
        check_eq("r_txreq", 32'(tx_req_total - tx_base), 32'd2);
        bus_stop();
        check_eq("r_busy_stop", 32'(Busy), 32'd0);

        // Write 0x11, repeated START, read
        rx_base = rx_obs.size();
        bus_start();
        write_byte({TGT_ADDR, 1'b0}, ack);
        check_eq("rs_w_rnw", 32'(ReadNotWrite), 32'd0);
        write_byte(8'h11, ack);
        check_eq("rs_w_ack", 32'(ack), 32'd1);
        tx_base = tx_req_total;
        tx_bytes[0] = 8'($urandom);
        bus_rep_start();
        write_byte({TGT_ADDR, 1'b1}, ack);
        check_eq("rs_r_ack", 32'(ack), 32'd1);
        check_eq("rs_r_rnw", 32'(ReadNotWrite), 32'd1);
        read_byte(1'b0, rb);
        check_eq("rs_r_data", 32'(rb), 32'(tx_bytes[0]));
        bus_stop();
        check_eq("rs_rx_cnt", 32'(rx_obs.size() - rx_base), 32'd1);
        if (rx_obs.size() - rx_base == 1)
            check_eq("rs_rx0", 32'(rx_obs[rx_base]), 32'h11);

        // Reset during bit 4 of a write data byte
        bus_start();
        write_byte({TGT_ADDR, 1'b0}, ack);
        for (int i = 0; i < 3; i++) clock_bit(1'b0, ack);
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #(Q/2) reset = 1'b1;
        #1;
        check_eq("mr_sda", 32'(SDADriveLow), 32'd0);
        check_eq("mr_busy", 32'(Busy), 32'd0);
        #30 reset = 1'b0;
        #(Q/2) scl_m = 1'b0;
        #Q;
        bus_stop();
        rx_base = rx_obs.size();
        bus_start();
        write_byte({TGT_ADDR, 1'b0}, ack);
        check_eq("mr_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h77, ack);
        check_eq("mr_d_ack", 32'(ack), 32'd1);
        bus_stop();
        check_eq("mr_rx_cnt", 32'(rx_obs.size() - rx_base), 32'd1);
        if (rx_obs.size() - rx_base == 1)
            check_eq("mr_rx0", 32'(rx_obs[rx_base]), 32'h77);

        // STOP mid-byte during a read (bit 5 of 0xF0 is a released 1)
        tx_base = tx_req_total;
        tx_bytes[0] = 8'hF0;
        tx_bytes[1] = 8'h00;
        bus_start();
        write_byte({TGT_ADDR, 1'b1}, ack);
        check_eq("ms_addr_ack", 32'(ack), 32'd1);
        clock_bit(1'b1, ack);
        clock_bit(1'b1, ack);
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #60;
        check_eq("ms_sda", 32'(SDADriveLow), 32'd0);
        check_eq("ms_busy", 32'(Busy), 32'd0);
        #(4*Q);
        check_eq("ms_txreq", 32'(tx_req_total - tx_base), 32'd1);

        // Randomized transactions against the transaction-level expectation
        for (int t = 0; t < 8; t++) begin
            match = 1'($urandom_range(0, 1));
            rw    = 1'($urandom_range(0, 1));
            n     = $urandom_range(1, 3);
            addr  = 7'($urandom);
            if (match) addr = TGT_ADDR;
            else if (addr == TGT_ADDR) addr = addr ^ 7'h01;
            rx_base = rx_obs.size();
            tx_base = tx_req_total;
            for (int i = 0; i < 3; i++) begin
                wbytes[i]   = 8'($urandom);
                tx_bytes[i] = 8'($urandom);
            end
            bus_start();
            write_byte({addr, rw}, ack);
            check_eq($sformatf("rnd%0d_aack", t), 32'(ack), 32'(match));
            check_eq($sformatf("rnd%0d_busy", t), 32'(Busy), 32'(match));
            for (int i = 0; i < n; i++) begin
                if (rw) begin
                    read_byte(i != n - 1, rb);
                    exp_byte = match ? tx_bytes[i] : 8'hFF;
                    check_eq($sformatf("rnd%0d_rd%0d", t, i), 32'(rb), 32'(exp_byte));
                end else begin
                    write_byte(wbytes[i], ack);
                    check_eq($sformatf("rnd%0d_wack%0d", t, i), 32'(ack), 32'(match));
                end
            end
            bus_stop();
            check_eq($sformatf("rnd%0d_rxn", t), 32'(rx_obs.size() - rx_base),
                     32'((match && !rw) ? n : 0));
            check_eq($sformatf("rnd%0d_txn", t), 32'(tx_req_total - tx_base),
                     32'((match && rw) ? n : 0));
            if (match && !rw && (rx_obs.size() - rx_base == n)) begin
                for (int i = 0; i < n; i++)
                    check_eq($sformatf("rnd%0d_rx%0d", t, i), 32'(rx_obs[rx_base+i]), 32'(wbytes[i]));
            end
        end

        check_eq("rxv_txr_overlap", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
